mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the single data port of the memory controller between the CPU load/store unit (master 0) and a secondary bus master such as the debug loader or DMA engine (master 1). Round-robin with optional bounded bus locking. It drives the controller's data-side signals, and routes the one-cycle-latency read data back to the master that issued the read. It sits between the core/peripheral masters and the memory controller data interface.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the memory controller data port between two masters, with bounded locking.
// Grant and o_mem_* are combinational (0-cycle); read data returns 1 cycle later; a losing master holds req until granted.
module mem_port_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [1:0]  i_m0_width,
  input  logic        i_m0_we,
  input  logic        i_m0_zeroextend,
  input  logic        i_m0_lock,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [1:0]  i_m1_width,
  input  logic        i_m1_we,
  input  logic        i_m1_zeroextend,
  input  logic        i_m1_lock,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_width,
  output logic        o_mem_we,
  output logic        o_mem_read_en,
  output logic        o_mem_zeroextend,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(LOCK_MAX);

  logic          last_q, last_d;
  logic          lock_flag_q, lock_flag_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;

  logic keep_last;
  logic sel;
  logic accept;
  logic sel_we;

  always_comb begin
    keep_last = lock_flag_q && (hold_cnt_q < HOLD_MAX);
    sel = 1'b0;
    if (i_m0_req && i_m1_req) begin
      sel = keep_last ? last_q : ~last_q;
    end else if (i_m1_req) begin
      sel = 1'b1;
    end
    // Grants are forced low while reset is held.
    accept   = i_rst_n && (i_m0_req || i_m1_req);
    o_m0_gnt = accept && !sel;
    o_m1_gnt = accept && sel;
    sel_we   = sel ? i_m1_we : i_m0_we;
  end

  always_comb begin
    o_mem_addr       = '0;
    o_mem_wdata      = '0;
    o_mem_width      = '0;
    o_mem_we         = 1'b0;
    o_mem_read_en    = 1'b0;
    o_mem_zeroextend = 1'b0;
    if (accept) begin
      o_mem_addr       = sel ? i_m1_addr : i_m0_addr;
      o_mem_wdata      = sel ? i_m1_wdata : i_m0_wdata;
      o_mem_width      = sel ? i_m1_width : i_m0_width;
      o_mem_zeroextend = sel ? i_m1_zeroextend : i_m0_zeroextend;
      o_mem_we         = sel_we;
      o_mem_read_en    = !sel_we;
    end
  end

  always_comb begin
    last_d      = last_q;
    lock_flag_d = lock_flag_q;
    hold_cnt_d  = hold_cnt_q;
    rd_pend_d   = 1'b0;
    rd_owner_d  = rd_owner_q;
    if (accept) begin
      last_d      = sel;
      lock_flag_d = sel ? i_m1_lock : i_m0_lock;
      if (sel == last_q) begin
        hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
      end else begin
        hold_cnt_d = CW'(1);
      end
      if (!sel_we) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = sel;
      end
    end
  end

  // last resets to master 1 so master 0 wins the first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q      <= 1'b1;
      lock_flag_q <= 1'b0;
      hold_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      lock_flag_q <= lock_flag_d;
      hold_cnt_q  <= hold_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  always_comb begin
    o_m0_rvalid = rd_pend_q && !rd_owner_q;
    o_m1_rvalid = rd_pend_q && rd_owner_q;
    o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic against a transfer-level model.
module tb_mem_port_arbiter;
  localparam int LOCK_MAX = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_zext, m0_lock;
  logic        m1_req, m1_we, m1_zext, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_width, m1_width;
  logic        gnt0, gnt1, rv0, rv1;
  logic [31:0] rd0, rd1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;
  logic        mem_we, mem_rd_en, mem_zext;
  logic        mem_clear;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_width(m0_width),
    .i_m0_we(m0_we), .i_m0_zeroextend(m0_zext), .i_m0_lock(m0_lock),
    .o_m0_gnt(gnt0), .o_m0_rvalid(rv0), .o_m0_rdata(rd0),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_width(m1_width),
    .i_m1_we(m1_we), .i_m1_zeroextend(m1_zext), .i_m1_lock(m1_lock),
    .o_m1_gnt(gnt1), .o_m1_rvalid(rv1), .o_m1_rdata(rd1),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_width(mem_width),
    .o_mem_we(mem_we), .o_mem_read_en(mem_rd_en), .o_mem_zeroextend(mem_zext),
    .i_mem_rdata(mem_rdata)
  );

  wire [68:0] dut_bus = {mem_addr, mem_wdata, mem_width, mem_we, mem_rd_en, mem_zext};

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h1000 + 32'h56;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                        input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (w)
      2'd1:    r[8*off +: 8] = d[7:0];
      2'd2:    r[16*off[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Simple controller: word-granular store, whole word returned one cycle after read_en.
  logic [31:0] ctl_mem [16];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) ctl_mem[i] <= init_word(i);
    end else if (mem_we) begin
      ctl_mem[mem_addr[5:2]] <= merge(ctl_mem[mem_addr[5:2]], mem_addr[1:0], mem_width, mem_wdata);
    end
    mem_rdata <= mem_rd_en ? ctl_mem[mem_addr[5:2]] : 32'hDEAD_BEEF;
  end

  // Reference model: who owned the port last, how long its run is, and whether it asked to keep it.
  logic        m_last, m_lock;
  int          m_run;
  logic [1:0]  exp_rv;
  logic [31:0] exp_rd;
  logic [31:0] ref_mem [16];

  task automatic model_reset();
    m_last = 1'b1; m_lock = 1'b0; m_run = 0; exp_rv = 2'b00; exp_rd = '0;
  endtask

  function automatic logic [1:0] exp_gnt();
    logic w;
    if (!rst_n || !(m0_req || m1_req)) return 2'b00;
    if (m0_req && !m1_req) return 2'b01;
    if (m1_req && !m0_req) return 2'b10;
    w = (m_lock && m_run < LOCK_MAX) ? m_last : !m_last;
    return w ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [68:0] exp_bus(input logic [1:0] g);
    if (g[0]) return {m0_addr, m0_wdata, m0_width, m0_we, !m0_we, m0_zext};
    if (g[1]) return {m1_addr, m1_wdata, m1_width, m1_we, !m1_we, m1_zext};
    return '0;
  endfunction

  task automatic commit(input logic [1:0] g);
    logic w;
    logic [31:0] a;
    exp_rv = 2'b00; exp_rd = '0;
    if (!rst_n) begin model_reset(); return; end
    if (g == 2'b00) return;
    w = g[1];
    if (w == m_last) m_run++;
    else begin m_last = w; m_run = 1; end
    m_lock = w ? m1_lock : m0_lock;
    a = w ? m1_addr : m0_addr;
    if (w ? m1_we : m0_we) begin
      ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], a[1:0], w ? m1_width : m0_width, w ? m1_wdata : m0_wdata);
    end else begin
      exp_rv = g; exp_rd = ref_mem[a[5:2]];
    end
  endtask

  task automatic tick();
    logic [1:0] g;
    g = exp_gnt();
    @(posedge clk);
    commit(g);
    #2;
  endtask

  task automatic drive(input int n, input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] width, input logic we, input logic zext, input logic lock);
    if (n == 0) begin
      m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_width = width; m0_we = we; m0_zext = zext; m0_lock = lock;
    end else begin
      m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_width = width; m1_we = we; m1_zext = zext; m1_lock = lock;
    end
  endtask

  task automatic test_reset();
    drive(0, 1, BASE, 0, 2'd0, 0, 0, 0);
    drive(1, 1, BASE + 4, 0, 2'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    n_checks++; if ({gnt1, gnt0} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", {gnt1, gnt0}); end
    n_checks++; if (dut_bus !== '0) begin n_fail++; $display("FAIL reset_mem_bus got %h exp 0", dut_bus); end
    n_checks++; if ({rv1, rv0, rd1, rd0} !== '0) begin n_fail++; $display("FAIL reset_rsp got rv=%b rd0=%h rd1=%h exp 0", {rv1, rv0}, rd0, rd1); end
    mem_clear = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL reset_first_gnt got %b exp 01", {gnt1, gnt0}); end
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b10) begin n_fail++; $display("FAIL reset_second_gnt got %b exp 10", {gnt1, gnt0}); end
    n_checks++; if (dut_bus !== {BASE + 32'd4, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_m1_bus got %h", dut_bus); end
    n_checks++; if ({rv1, rv0} !== 2'b01 || rd0 !== 32'h0000_0056 || rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_m0_rsp got rv=%b rd0=%h rd1=%h exp 01/00000056/0", {rv1, rv0}, rd0, rd1); end
    tick();
    drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({rv1, rv0} !== 2'b10 || rd1 !== 32'h0000_1056 || rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_m1_rsp got rv=%b rd0=%h rd1=%h exp 10/0/00001056", {rv1, rv0}, rd0, rd1); end
    tick();
    #1;
    n_checks++; if ({rv1, rv0} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_done got %b exp 00", {rv1, rv0}); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp, prev;
    prev = 2'b00;
    drive(0, 1, BASE + 8, 0, 2'd0, 0, 0, 0);
    drive(1, 1, BASE + 12, 0, 2'd0, 0, 0, 0);
    #1;
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if ({gnt1, gnt0} !== exp) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, {gnt1, gnt0}, exp); end
      if (i > 0) begin
        n_checks++;
        if ({rv1, rv0} !== prev || (prev[0] && rd0 !== init_word(2)) || (prev[1] && rd1 !== init_word(3))) begin
          n_fail++; $display("FAIL rr_rsp[%0d] got rv=%b rd0=%h rd1=%h exp rv=%b", i, {rv1, rv0}, rd0, rd1, prev);
        end
      end
      prev = exp;
      tick();
      #1;
    end
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({rv1, rv0} !== 2'b10 || rd1 !== init_word(3)) begin n_fail++; $display("FAIL rr_last_rsp got rv=%b rd1=%h", {rv1, rv0}, rd1); end
    tick();
  endtask

  task automatic test_lock_bound();
    drive(0, 1, BASE + 16, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL lock_prime got %b exp 01", {gnt1, gnt0}); end
    tick();
    drive(1, 1, BASE + 20, 0, 2'd0, 0, 0, 1);
    #1;
    for (int i = 0; i < LOCK_MAX; i++) begin
      n_checks++; if ({gnt1, gnt0} !== 2'b10) begin n_fail++; $display("FAIL lock_hold[%0d] got %b exp 10", i, {gnt1, gnt0}); end
      tick();
      #1;
    end
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL lock_release got %b exp 01", {gnt1, gnt0}); end
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if ({gnt1, gnt0} !== 2'b10) begin n_fail++; $display("FAIL lock_solo[%0d] got %b exp 10", i, {gnt1, gnt0}); end
      tick();
      #1;
    end
    drive(0, 1, BASE + 16, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL lock_saturated got %b exp 01", {gnt1, gnt0}); end
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    tick();
  endtask

  task automatic test_write();
    drive(1, 1, BASE + 2, 32'h0000_00A5, 2'd1, 1, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b10) begin n_fail++; $display("FAIL wr_gnt got %b exp 10", {gnt1, gnt0}); end
    n_checks++; if (dut_bus !== {BASE + 32'd2, 32'h0000_00A5, 2'd1, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL wr_bus got %h", dut_bus); end
    tick();
    drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 1, BASE, 0, 2'd2, 0, 1, 0);
    #1;
    n_checks++; if ({rv1, rv0} !== 2'b00) begin n_fail++; $display("FAIL wr_no_rvalid got %b exp 00", {rv1, rv0}); end
    n_checks++; if (dut_bus !== {BASE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL rd_half_bus got %h", dut_bus); end
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({rv1, rv0} !== 2'b01 || rd0 !== 32'h00A5_0056) begin n_fail++; $display("FAIL rd_after_wr got rv=%b rd0=%h exp 01/00a50056", {rv1, rv0}, rd0); end
    tick();
  endtask

  task automatic test_reset_during_read();
    drive(0, 1, BASE + 4, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL rst_rd_gnt got %b exp 01", {gnt1, gnt0}); end
    #2;
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0, rv1, rv0} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_outputs got gnt=%b rv=%b exp 0", {gnt1, gnt0}, {rv1, rv0}); end
    tick();
    #1;
    n_checks++; if ({rv1, rv0} !== 2'b00) begin n_fail++; $display("FAIL rst_no_rvalid got %b exp 00", {rv1, rv0}); end
    tick();
    rst_n = 1'b1;
    drive(0, 1, BASE + 8, 0, 2'd0, 0, 0, 0);
    drive(1, 1, BASE + 12, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL rst_first_contention got %b exp 01", {gnt1, gnt0}); end
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b10 || {rv1, rv0} !== 2'b01 || rd0 !== init_word(2)) begin n_fail++; $display("FAIL rst_recover got gnt=%b rv=%b rd0=%h", {gnt1, gnt0}, {rv1, rv0}, rd0); end
    tick();
    drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    tick();
  endtask

  task automatic test_random();
    logic p0, p1;
    logic [1:0] g;
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!p0) begin
        if ($urandom_range(0, 9) < 6)
          drive(0, 1, BASE | 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        else drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
      end
      if (!p1) begin
        if ($urandom_range(0, 9) < 6)
          drive(1, 1, BASE | 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        else drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
      end
      #1;
      g = exp_gnt();
      n_checks++; if ({gnt1, gnt0} !== g) begin n_fail++; $display("FAIL rand_gnt[%0d] got %b exp %b", c, {gnt1, gnt0}, g); end
      n_checks++; if (dut_bus !== exp_bus(g)) begin n_fail++; $display("FAIL rand_bus[%0d] got %h exp %h", c, dut_bus, exp_bus(g)); end
      n_checks++; if ({rv1, rv0} !== exp_rv) begin n_fail++; $display("FAIL rand_rvalid[%0d] got %b exp %b", c, {rv1, rv0}, exp_rv); end
      n_checks++;
      if (rd0 !== (exp_rv[0] ? exp_rd : 32'h0) || rd1 !== (exp_rv[1] ? exp_rd : 32'h0)) begin
        n_fail++; $display("FAIL rand_rdata[%0d] got rd0=%h rd1=%h exp rv=%b data=%h", c, rd0, rd1, exp_rv, exp_rd);
      end
      p0 = m0_req && !g[0];
      p1 = m1_req && !g[1];
      tick();
    end
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
    #1;
    n_checks++; if ({rv1, rv0} !== exp_rv) begin n_fail++; $display("FAIL rand_tail_rvalid got %b exp %b", {rv1, rv0}, exp_rv); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_clear = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
    model_reset();
    test_reset();
    test_round_robin();
    test_lock_bound();
    test_write();
    test_reset_during_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
